// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues instruction reads, loads the IF/ID register.
// Optional IF_STATIC_JUMP_EN: redirect PC on JMP/JAL words at fetch time.
module instruction_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_mem_read,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_pc_next,
    output logic                 if_id_valid
);

    localparam logic [WORD_SIZE-1:0] ONE = 1;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] inst;
        logic [WORD_SIZE-1:0] pc_next;
        logic                 valid;
    } if_id_t;

    state_t               state, state_nxt;
    logic [WORD_SIZE-1:0] pc, pc_nxt;
    logic [WORD_SIZE-1:0] hold_buf, hold_nxt;
    if_id_t               if_id, if_id_nxt;

    logic [WORD_SIZE-1:0] pc_inc;
    logic [WORD_SIZE-1:0] fetch_npc;
    logic [WORD_SIZE-1:0] hold_npc;

    assign pc_inc = pc + ONE;

`ifdef IF_STATIC_JUMP_EN
    localparam logic [3:0] JMP_OP = 4'd9;
    localparam logic [3:0] JAL_OP = 4'd10;

    // Absolute jump target keeps the page bits of the current PC.
    function automatic logic [WORD_SIZE-1:0] jump_npc(
        input logic [WORD_SIZE-1:0] cur_pc,
        input logic [WORD_SIZE-1:0] inc_pc,
        input logic [WORD_SIZE-1:0] word
    );
        logic [3:0] op;
        op = word[WORD_SIZE-1 -: 4];
        if (op == JMP_OP || op == JAL_OP)
            return {cur_pc[WORD_SIZE-1:12], word[11:0]};
        return inc_pc;
    endfunction

    assign fetch_npc = jump_npc(pc, pc_inc, i_data);
    assign hold_npc  = jump_npc(pc, pc_inc, hold_buf);
`else
    assign fetch_npc = pc_inc;
    assign hold_npc  = pc_inc;
`endif

    // Next-state and request decode; priority flush > halt > stall.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        hold_nxt   = hold_buf;
        if_id_nxt  = if_id;
        i_mem_read = (state == FETCH) && !reset_n;
        i_address  = pc;
        if (state == HALTED) begin
            if_id_nxt.valid = 1'b0;
        end else if (flush) begin
            pc_nxt          = redirect_pc;
            hold_nxt        = '0;
            if_id_nxt.valid = 1'b0;
            state_nxt       = FETCH;
        end else if (halt) begin
            if_id_nxt.valid = 1'b0;
            state_nxt       = HALTED;
        end else begin
            unique case (state)
                FETCH: begin
                    unique case (1'b1)
                        i_ready && !stall: begin
                            if_id_nxt = '{i_data, pc_inc, 1'b1};
                            pc_nxt    = fetch_npc;
                        end
                        i_ready && stall: begin
                            hold_nxt  = i_data;
                            state_nxt = HOLD;
                        end
                        !i_ready && !stall: begin
                            if_id_nxt.valid = 1'b0;
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_nxt = '{hold_buf, pc_inc, 1'b1};
                        pc_nxt    = hold_npc;
                        state_nxt = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            hold_buf <= '0;
            if_id    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_nxt;
            if_id    <= if_id_nxt;
        end
    end

    assign if_id_inst    = if_id.inst;
    assign if_id_pc_next = if_id.pc_next;
    assign if_id_valid   = if_id.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic
// checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_mem_read;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc_next;
    logic        if_id_valid;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_mem_read    (i_mem_read),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_ready       (i_ready),
        .stall         (stall),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .if_id_inst    (if_id_inst),
        .if_id_pc_next (if_id_pc_next),
        .if_id_valid   (if_id_valid)
    );

`ifdef IF_STATIC_JUMP_EN
    localparam logic [3:0] JMP_OP = 4'd9;
    localparam logic [3:0] JAL_OP = 4'd10;
`endif

    logic [15:0] mem [0:65535];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: PC, pending held word, halted flag, IF/ID contents.
    logic [15:0] m_pc = 16'h0;
    bit          m_halted = 1'b0;
    bit          m_rst = 1'b1;
    logic [15:0] hold_q [$];
    logic [15:0] m_inst = 16'h0;
    logic [15:0] m_pcn = 16'h0;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] ref_next(input logic [15:0] pc,
                                             input logic [15:0] w);
`ifdef IF_STATIC_JUMP_EN
        if (w[15:12] == JMP_OP || w[15:12] == JAL_OP)
            return {pc[15:12], w[11:0]};
`endif
        return pc + 16'd1;
    endfunction

    function automatic bit m_rd();
        return !m_rst && !m_halted && hold_q.size() == 0;
    endfunction

    task automatic accept(input logic [15:0] w);
        m_inst  = w;
        m_pcn   = m_pc + 16'd1;
        m_valid = 1'b1;
        m_pc    = ref_next(m_pc, w);
    endtask

    // One clock: drive at negedge, update model at posedge, settle 1 time unit.
    task automatic step(input bit r, input bit st, input bit fl,
                        input bit hl, input bit rdy, input logic [15:0] rpc);
        logic [15:0] w;
        @(negedge clk);
        reset_n     = r;
        stall       = st;
        flush       = fl;
        halt        = hl;
        i_ready     = rdy;
        redirect_pc = rpc;
        i_data      = rdy ? mem[m_pc] : 16'($urandom);
        @(posedge clk);
        if (r) begin
            m_pc = 16'h0; m_halted = 0; hold_q.delete();
            m_inst = 16'h0; m_pcn = 16'h0; m_valid = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (fl) begin
            m_pc = rpc; m_valid = 0; hold_q.delete();
        end else if (hl) begin
            m_halted = 1; m_valid = 0; hold_q.delete();
        end else if (hold_q.size() > 0) begin
            if (!st) begin
                w = hold_q.pop_front();
                accept(w);
            end
        end else if (rdy && !st) begin
            accept(mem[m_pc]);
        end else if (rdy) begin
            hold_q.push_back(mem[m_pc]);
        end else if (!st) begin
            m_valid = 0;
        end
        m_rst = r;
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        n_chk++;
        if (i_mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rd got %b want 0", i_mem_read);
        end
        n_chk++;
        if ({if_id_inst, if_id_pc_next, if_id_valid} !== 33'h0) begin
            n_fail++;
            $display("FAIL rst_ifid got %h/%h/%b want 0/0/0",
                     if_id_inst, if_id_pc_next, if_id_valid);
        end
        n_chk++;
        if (i_address !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_addr got %h want 0000", i_address);
        end
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 1, 0);
            n_chk++;
            if (i_address !== 16'(k) || if_id_pc_next !== 16'(k) ||
                if_id_valid !== 1'b1 || if_id_inst !== mem[k-1] ||
                i_mem_read !== 1'b1) begin
                n_fail++;
                $display("FAIL seq%0d got a=%h pcn=%h v=%b i=%h want a=%h pcn=%h v=1 i=%h",
                         k, i_address, if_id_pc_next, if_id_valid,
                         if_id_inst, 16'(k), 16'(k), mem[k-1]);
            end
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (i_address !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_pre got %h want 0005", i_address);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 1, 0);
            n_chk++;
            if (i_mem_read !== 1'b0 || if_id_pc_next !== 16'd5 ||
                if_id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d got rd=%b pcn=%h v=%b want rd=0 pcn=0005 v=1",
                         k, i_mem_read, if_id_pc_next, if_id_valid);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (if_id_pc_next !== 16'd6 || if_id_inst !== mem[5] ||
            if_id_valid !== 1'b1 || i_address !== 16'd6 ||
            i_mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_rel got pcn=%h i=%h v=%b a=%h rd=%b want pcn=0006 i=%h v=1 a=0006 rd=1",
                     if_id_pc_next, if_id_inst, if_id_valid, i_address,
                     i_mem_read, mem[5]);
        end
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (if_id_pc_next !== 16'd7 || if_id_inst !== mem[6]) begin
            n_fail++;
            $display("FAIL stall_resume got pcn=%h i=%h want pcn=0007 i=%h",
                     if_id_pc_next, if_id_inst, mem[6]);
        end
    endtask

    task automatic test_flush();
        step(0, 1, 1, 0, 1, 16'h0040);
        n_chk++;
        if (if_id_valid !== 1'b0 || i_address !== 16'h0040 ||
            i_mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL flush got v=%b a=%h rd=%b want v=0 a=0040 rd=1",
                     if_id_valid, i_address, i_mem_read);
        end
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (if_id_pc_next !== 16'h0041 || if_id_inst !== mem[16'h40] ||
            if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_next got pcn=%h i=%h v=%b want pcn=0041 i=%h v=1",
                     if_id_pc_next, if_id_inst, if_id_valid, mem[16'h40]);
        end
    endtask

    task automatic test_ready_toggle();
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, bit'(k % 2), 0);
            n_chk++;
            if (if_id_valid !== 1'(k % 2) ||
                i_address !== 16'((k + 1) / 2) ||
                (k % 2 == 1 && if_id_pc_next !== 16'((k + 1) / 2))) begin
                n_fail++;
                $display("FAIL toggle%0d got v=%b a=%h pcn=%h want v=%0d a=%h",
                         k, if_id_valid, i_address, if_id_pc_next,
                         k % 2, 16'((k + 1) / 2));
            end
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 0, 0, 16'hFFFF);
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (i_address !== 16'h0000 || if_id_pc_next !== 16'h0000 ||
            if_id_inst !== mem[16'hFFFF]) begin
            n_fail++;
            $display("FAIL wrap got a=%h pcn=%h i=%h want a=0000 pcn=0000 i=%h",
                     i_address, if_id_pc_next, if_id_inst, mem[16'hFFFF]);
        end
    endtask

    task automatic test_jump_halt();
        logic [15:0] frozen;
`ifdef IF_STATIC_JUMP_EN
        mem[16'h2010] = {JAL_OP, 12'h123};
        mem[16'h2123] = {JMP_OP, 12'h456};
        step(0, 0, 1, 0, 0, 16'h2010);
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (i_address !== 16'h2123 || if_id_pc_next !== 16'h2011 ||
            if_id_inst !== mem[16'h2010] || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL jal got a=%h pcn=%h i=%h v=%b want a=2123 pcn=2011",
                     i_address, if_id_pc_next, if_id_inst, if_id_valid);
        end
        step(0, 0, 0, 0, 1, 0);
        n_chk++;
        if (i_address !== 16'h2456 || if_id_pc_next !== 16'h2124) begin
            n_fail++;
            $display("FAIL jmp got a=%h pcn=%h want a=2456 pcn=2124",
                     i_address, if_id_pc_next);
        end
`endif
        frozen = m_pc;
        step(0, 0, 0, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (i_mem_read !== 1'b0 || if_id_valid !== 1'b0 ||
                i_address !== frozen) begin
                n_fail++;
                $display("FAIL halt%0d got rd=%b v=%b a=%h want rd=0 v=0 a=%h",
                         k, i_mem_read, if_id_valid, i_address, frozen);
            end
            step(0, bit'(k == 1), bit'(k == 2), 0, 1, 16'h0300);
        end
        step(1, 0, 0, 0, 0, 0);
        n_chk++;
        if (i_address !== 16'h0 || if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit got a=%h v=%b want a=0000 v=0",
                     i_address, if_id_valid);
        end
    endtask

    task automatic test_random();
        bit r, st, fl, hl, rdy;
        for (int a = 0; a < 512; a++) mem[a] = 16'($urandom);
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 800; k++) begin
            r   = ($urandom % 100) == 0;
            fl  = ($urandom % 100) < 5;
            hl  = ($urandom % 200) == 0;
            st  = ($urandom % 100) < 35;
            rdy = ($urandom % 100) < 70;
            step(0 | r, st, fl, hl, rdy, 16'($urandom % 512));
            n_chk++;
            if (i_mem_read !== m_rd() || i_address !== m_pc ||
                if_id_inst !== m_inst || if_id_pc_next !== m_pcn ||
                if_id_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand%0d got rd=%b a=%h i=%h pcn=%h v=%b want rd=%b a=%h i=%h pcn=%h v=%b",
                         k, i_mem_read, i_address, if_id_inst,
                         if_id_pc_next, if_id_valid, m_rd(), m_pc,
                         m_inst, m_pcn, m_valid);
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        reset_n = 1'b1; stall = 0; flush = 0; halt = 0;
        i_ready = 0; redirect_pc = 0; i_data = 0;
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'd9 || w[15:12] == 4'd10) w[15:12] = 4'd0;
            mem[a] = w;
        end
        test_reset();
        test_stall();
        test_flush();
        test_ready_toggle();
        test_wrap();
        test_jump_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
